kersram_w: RTL and testbench
============================

Name: kersram_w

Overview:
Kernel SRAM write/load engine, the fill side of the 8-bank kernel SRAM read path. It accepts a valid/ready word stream of kernel weights from the DMA/input buffer after a start pulse. Each word goes to one of the 8 kernel SRAM banks, using the same address map the read engine walks: bank-local address = ker_idx*ONCE_CP + word_idx. It raises busy while loading and pulses done once the full layer's kernels are stored.

Parameters:
DATA_W, 64, SRAM word width (8 channels x 8-bit weights)
ADDR_W, 11, SRAM address width
CH_ADDR, 4, input channels / 8 (addresses per pixel)
CP_PIX, 9, pixels per kernel (3x3)
KER_NUM, 8, kernel groups per bank (output channels / 8)
SRAM_NUM, 8, number of kernel SRAM banks (fixed at 8)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
start_ker_write  input  1  one-cycle start pulse, honoured only in IDLE
ker_write_busy  output  1  high while loading
ker_write_done  output  1  one-cycle pulse when the last word is written
din  input  DATA_W  kernel word
din_valid  input  1  din valid
din_ready  output  1  engine accepts din
cen_kersw  output  SRAM_NUM  per-bank chip enable, active-low
wen_kersw  output  SRAM_NUM  per-bank write enable, active-low
addr_kersw  output  ADDR_W  shared bank address
din_kersw  output  DATA_W  shared bank write data

Behaviour:
- Derived constants: ONCE_CP = CH_ADDR*CP_PIX (36). TOTAL = ONCE_CP*SRAM_NUM*KER_NUM (2304).
- Stream order:
  - for ker_idx 0..KER_NUM-1, for bank 0..SRAM_NUM-1, for word_idx 0..ONCE_CP-1.
  - Three nested counters: word_idx (innermost), bank, ker_idx. Each wraps to 0 at its terminal value.
- FSM IDLE -> LOAD -> DONE -> IDLE:
  - IDLE: start_ker_write moves to LOAD and clears all counters.
  - LOAD: din_ready=1. A beat is accepted when din_valid & din_ready.
  - LOAD -> DONE on acceptance of beat TOTAL-1 (word_idx=ONCE_CP-1, bank=SRAM_NUM-1, ker_idx=KER_NUM-1).
  - DONE: lasts one cycle, din_ready=0, then returns to IDLE.
- ker_write_busy = (state==LOAD). ker_write_done = (state==DONE).
- din_ready is 0 in IDLE and DONE.
- Write port timing:
  - Registered, latency 1. A beat accepted at edge E drives these outputs for exactly the cycle after E:
    - cen_kersw[bank]=0 and wen_kersw[bank]=0.
    - addr_kersw = ker_idx*ONCE_CP + word_idx, computed at ADDR_W width. Use a base register that steps by ONCE_CP; no multiplier.
    - din_kersw = din.
  - With no beat accepted, all cen/wen bits = 1 and addr/data hold their previous values.
  - At most one bank is strobed per cycle.
- The last write strobe coincides with ker_write_done=1.
- Backpressure: din_valid low stalls all counters. Any gap length is legal and no write is issued during a gap.
- start_ker_write while not in IDLE is ignored. start and din_valid in the same IDLE cycle: that din is not accepted.
- Reset (asynchronous, active-low):
  - state=IDLE, counters=0.
  - cen_kersw=all 1s, wen_kersw=all 1s, addr_kersw=0, din_kersw=0.
  - ker_write_busy=0, ker_write_done=0, din_ready=0.
  - Mid-load reset abandons the load; a new start is required.

Optional Feature:
Macro KERSRAM_W_CHKSUM_EN.
- Defined:
  - Adds output ker_chksum[15:0]: a running 16-bit wraparound sum of the four 16-bit lanes of every accepted din.
  - Cleared on reset and on an accepted start; updated at the same edge the beat is accepted.
  - Stable from DONE until the next start.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Shared package kersram_pkg:
  - Constants CH_ADDR, CP_PIX, KER_NUM, SRAM_NUM, ONCE_CP, TOTAL and the FSM state encodings (IDLE/LOAD/DONE).
  - Shared with the read engine so both sides use one address map.
- One natural sub-module, kersram_w_addrgen: the word/bank/ker counters and base-address adder.
  - Inputs: step, clear.
  - Outputs: bank, addr, last.

Test Plan:
- Reset, start, then 2304 back-to-back beats with din=beat index -> these strobes on the cycle after each acceptance:
  - beat 0 -> bank0 addr0; beat 35 -> bank0 addr35; beat 36 -> bank1 addr0.
  - beat 288 -> bank0 addr36; beat 2303 -> bank7 addr287, with done=1 in that cycle.
  - busy high for exactly 2304 cycles.
- Same load with din_valid toggling 1/0 every cycle -> addresses identical to the back-to-back run, no strobe in gap cycles, done after 4607 cycles of LOAD.
- Pulse start during LOAD at beat 100 -> ignored; counters continue and beat 101 -> bank2 addr29.
- Assert reset at beat 500 -> all cen/wen=1 immediately (asynchronous), busy=0. A new start followed by beat 0 -> bank0 addr0.
- din_valid held high in IDLE with no start -> din_ready=0, no strobes, state stays IDLE.
- With KERSRAM_W_CHKSUM_EN, 2304 beats of din=64'h0001_0001_0001_0001 -> ker_chksum=16'h2400 at DONE.

Source files
------------

// File: rtl/kersram_pkg.sv
// Shared kernel SRAM constants and FSM encoding, used by both the fill and read engines
// so the two sides agree on one address map.
package kersram_pkg;
    localparam int CH_ADDR  = 4;
    localparam int CP_PIX   = 9;
    localparam int KER_NUM  = 8;
    localparam int SRAM_NUM = 8;
    localparam int ONCE_CP  = CH_ADDR * CP_PIX;
    localparam int TOTAL    = ONCE_CP * SRAM_NUM * KER_NUM;

    localparam int WORD_W = $clog2(ONCE_CP);
    localparam int BANK_W = $clog2(SRAM_NUM);
    localparam int KER_W  = $clog2(KER_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ker_state_e;
endpackage

// File: rtl/kersram_w_addrgen.sv
// Word/bank/kernel counters for the kernel fill stream; bank and addr describe the current beat.
// Combinational outputs, counters advance on i_step; holding i_step low stalls everything.
// i_clear has priority and returns every counter to zero.
module kersram_w_addrgen
    import kersram_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_step,
    input  logic              i_clear,
    output logic [BANK_W-1:0] o_bank,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(ONCE_CP - 1);
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(SRAM_NUM - 1);
    localparam logic [KER_W-1:0]  KER_LAST  = KER_W'(KER_NUM - 1);

    logic [WORD_W-1:0] r_word;
    logic [BANK_W-1:0] r_bank;
    logic [KER_W-1:0]  r_ker;
    logic [ADDR_W-1:0] r_base;
    logic              w_word_wrap;
    logic              w_bank_wrap;

    assign w_word_wrap = (r_word == WORD_LAST);
    assign w_bank_wrap = (r_bank == BANK_LAST);

    // r_base tracks ker_idx*ONCE_CP so the address needs only an adder.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word <= '0;
            r_bank <= '0;
            r_ker  <= '0;
            r_base <= '0;
        end else if (i_clear) begin
            r_word <= '0;
            r_bank <= '0;
            r_ker  <= '0;
            r_base <= '0;
        end else if (i_step) begin
            if (w_word_wrap) begin
                r_word <= '0;
                if (w_bank_wrap) begin
                    r_bank <= '0;
                    if (r_ker == KER_LAST) begin
                        r_ker  <= '0;
                        r_base <= '0;
                    end else begin
                        r_ker  <= r_ker + 1'b1;
                        r_base <= r_base + ADDR_W'(ONCE_CP);
                    end
                end else begin
                    r_bank <= r_bank + 1'b1;
                end
            end else begin
                r_word <= r_word + 1'b1;
            end
        end
    end

    assign o_bank = r_bank;
    assign o_addr = r_base + ADDR_W'(r_word);
    assign o_last = w_word_wrap && w_bank_wrap && (r_ker == KER_LAST);
endmodule

// File: rtl/kersram_w.sv
// Kernel SRAM fill engine: streams TOTAL weight words into 8 banks (optional KERSRAM_W_CHKSUM_EN).
// Write strobe/addr/data registered, one cycle after beat acceptance; done coincides with last strobe.
// din_ready high only in LOAD; din_valid low stalls all counters and issues no write.
module kersram_w
    import kersram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_ker_write,
    output logic                ker_write_busy,
    output logic                ker_write_done,
    input  logic [DATA_W-1:0]   din,
    input  logic                din_valid,
    output logic                din_ready,
    output logic [SRAM_NUM-1:0] cen_kersw,
    output logic [SRAM_NUM-1:0] wen_kersw,
    output logic [ADDR_W-1:0]   addr_kersw,
    output logic [DATA_W-1:0]   din_kersw
`ifdef KERSRAM_W_CHKSUM_EN
    ,
    output logic [15:0]         ker_chksum
`endif
);
    ker_state_e        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;
    logic [SRAM_NUM-1:0] r_cen;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dat;

    logic              w_accept;
    logic              w_clear;
    logic [BANK_W-1:0] w_bank;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;

    assign w_accept = din_valid & r_ready;
    assign w_clear  = (r_state == IDLE) & start_ker_write;

    kersram_w_addrgen #(.ADDR_W(ADDR_W)) u_addrgen (
        .clk     (clk),
        .reset   (reset),
        .i_step  (w_accept),
        .i_clear (w_clear),
        .o_bank  (w_bank),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_ker_write) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                    r_ready <= 1'b1;
                end
                LOAD: if (w_accept && w_last) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_done  <= 1'b1;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Address and data hold between writes; only the strobes fall back to idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cen  <= '1;
            r_addr <= '0;
            r_dat  <= '0;
        end else begin
            r_cen <= w_accept ? ~(SRAM_NUM'(1) << w_bank) : '1;
            if (w_accept) begin
                r_addr <= w_addr;
                r_dat  <= din;
            end
        end
    end

`ifdef KERSRAM_W_CHKSUM_EN
    logic [15:0] r_chksum;
    logic [15:0] w_lane_sum;

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < DATA_W / 16; k++) begin
            w_lane_sum = w_lane_sum + din[16*k +: 16];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chksum <= '0;
        end else if (w_clear) begin
            r_chksum <= '0;
        end else if (w_accept) begin
            r_chksum <= r_chksum + w_lane_sum;
        end
    end

    assign ker_chksum = r_chksum;
`endif

    assign ker_write_busy = r_busy;
    assign ker_write_done = r_done;
    assign din_ready      = r_ready;
    assign cen_kersw      = r_cen;
    assign wen_kersw      = r_cen;
    assign addr_kersw     = r_addr;
    assign din_kersw      = r_dat;
endmodule

// File: tb/tb_kersram_w.sv
// Bench for kersram_w: cycle scoreboard against an arithmetic stream model plus
// a table of landmark beats and hand sequences for gaps, restart and reset.
module tb_kersram_w;
    import kersram_pkg::*;
    localparam int DW = 64;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          din_valid = 1'b0;
    logic [DW-1:0] din = '0;
    logic          busy, done, din_ready;
    logic [7:0]    cen, wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] dink;
`ifdef KERSRAM_W_CHKSUM_EN
    logic [15:0]   chks;
`endif

    kersram_w #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_ker_write (start),
        .ker_write_busy  (busy),
        .ker_write_done  (done),
        .din             (din),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .cen_kersw       (cen),
        .wen_kersw       (wen),
        .addr_kersw      (addr),
        .din_kersw       (dink)
`ifdef KERSRAM_W_CHKSUM_EN
        ,
        .ker_chksum      (chks)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: beat n lands in bank (n/36)%8 at (n/288)*36 + n%36.
    typedef enum {M_IDLE, M_LOAD, M_DONE} mst_t;
    mst_t        m_st;
    int          m_cnt, m_bank, m_addr;
    bit          m_wr;
    logic [63:0] m_data;
    logic [15:0] m_chk;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_st = M_IDLE; m_cnt = 0; m_wr = 0; m_bank = 0; m_addr = 0; m_data = '0; m_chk = '0;
        end else begin
            m_wr = 0;
            case (m_st)
                M_IDLE: if (start) begin m_st = M_LOAD; m_cnt = 0; m_chk = '0; end
                M_LOAD: if (din_valid) begin
                    m_wr   = 1;
                    m_bank = (m_cnt / ONCE_CP) % SRAM_NUM;
                    m_addr = (m_cnt / (ONCE_CP * SRAM_NUM)) * ONCE_CP + m_cnt % ONCE_CP;
                    m_data = din;
                    m_chk  = m_chk + din[15:0] + din[31:16] + din[47:32] + din[63:48];
                    m_cnt++;
                    if (m_cnt == TOTAL) m_st = M_DONE;
                end
                M_DONE: m_st = M_IDLE;
            endcase
        end
    end

    int log_bank[TOTAL];
    int log_addr[TOTAL];
    int log_n = 0;
    int busy_cyc = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (reset) begin
            logic [7:0] e_cen;
            bit bad;
            e_cen = m_wr ? ~(8'b1 << m_bank) : 8'hFF;
            bad = (cen !== e_cen) || (wen !== e_cen) || (addr !== AW'(m_addr)) || (dink !== m_data)
                  || (busy !== (m_st == M_LOAD)) || (done !== (m_st == M_DONE))
                  || (din_ready !== (m_st == M_LOAD));
`ifdef KERSRAM_W_CHKSUM_EN
            bad = bad || (chks !== m_chk);
`endif
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t cen=%h/%h wen=%h addr=%0d/%0d dat=%h/%h busy=%b/%b done=%b/%b rdy=%b/%b",
                         $time, cen, e_cen, wen, addr, m_addr, dink, m_data, busy, m_st == M_LOAD,
                         done, m_st == M_DONE, din_ready, m_st == M_LOAD);
            end
            if (cen !== 8'hFF && log_n < TOTAL) begin
                log_bank[log_n] = -1;
                for (int b = 0; b < 8; b++) if (cen[b] == 1'b0) log_bank[log_n] = b;
                log_addr[log_n] = int'(addr);
                log_n++;
            end
            if (busy === 1'b1) busy_cyc++;
            if (done === 1'b1) done_cyc++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int nbeats, input bit toggle, input int start_at, input bit ones);
        int sent = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        while (sent < nbeats && cyc < 20000) begin
            din_valid = toggle ? ph : 1'b1;
            din       = ones ? 64'h0001_0001_0001_0001 : 64'(sent);
            start     = (sent == start_at);
            @(negedge clk);
            acc = din_valid && din_ready;
            tick();
            if (acc) sent++;
            ph = ~ph;
            cyc++;
        end
        din_valid = 1'b0;
        start = 1'b0;
        if (sent < nbeats) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d beats expected %0d", sent, nbeats);
        end
    endtask

    task automatic clear_logs();
        log_n = 0;
        busy_cyc = 0;
        done_cyc = 0;
    endtask

    typedef struct { int beat; int bank; int addr; } vec_t;
    vec_t tbl[6];

    task automatic check_tbl(input int first, input int last_i);
        for (int i = first; i <= last_i; i++) begin
            chk($sformatf("tbl_bank_beat%0d", tbl[i].beat), 64'(log_bank[tbl[i].beat]), 64'(tbl[i].bank));
            chk($sformatf("tbl_addr_beat%0d", tbl[i].beat), 64'(log_addr[tbl[i].beat]), 64'(tbl[i].addr));
        end
    endtask

    int a_bank[TOTAL];
    int a_addr[TOTAL];

    initial begin
        int diffs;
        tbl[0] = '{0, 0, 0};
        tbl[1] = '{35, 0, 35};
        tbl[2] = '{36, 1, 0};
        tbl[3] = '{288, 0, 36};
        tbl[4] = '{2303, 7, 287};
        tbl[5] = '{101, 2, 29};

        // Reset values
        #12;
        chk("rst_cen", 64'(cen), 64'hFF);
        chk("rst_wen", 64'(wen), 64'hFF);
        chk("rst_addr", 64'(addr), 64'h0);
        chk("rst_din_kersw", dink, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_ready", 64'(din_ready), 64'h0);
        tick();
        reset = 1'b1;
        tick();

        // din_valid in IDLE without start must not be taken
        clear_logs();
        din_valid = 1'b1;
        repeat (10) tick();
        din_valid = 1'b0;
        chk("idle_no_strobe", 64'(log_n), 64'h0);
        chk("idle_no_busy", 64'(busy_cyc), 64'h0);

        // Back-to-back load
        clear_logs();
        start_pulse();
        feed(TOTAL, 1'b0, -1, 1'b0);
        chk("b2b_done_at_last", 64'(done), 64'h1);
        repeat (3) tick();
        chk("b2b_strobes", 64'(log_n), 64'(TOTAL));
        chk("b2b_busy_cycles", 64'(busy_cyc), 64'(TOTAL));
        chk("b2b_done_cycles", 64'(done_cyc), 64'h1);
        check_tbl(0, 5);
        for (int i = 0; i < TOTAL; i++) begin a_bank[i] = log_bank[i]; a_addr[i] = log_addr[i]; end

        // Valid toggling every cycle
        clear_logs();
        start_pulse();
        feed(TOTAL, 1'b1, -1, 1'b0);
        repeat (3) tick();
        chk("tog_strobes", 64'(log_n), 64'(TOTAL));
        chk("tog_busy_cycles", 64'(busy_cyc), 64'(2 * TOTAL - 1));
        chk("tog_done_cycles", 64'(done_cyc), 64'h1);
        diffs = 0;
        for (int i = 0; i < TOTAL; i++)
            if (a_bank[i] != log_bank[i] || a_addr[i] != log_addr[i]) diffs++;
        chk("tog_same_addrs", 64'(diffs), 64'h0);

        // Start pulse during LOAD is ignored
        clear_logs();
        start_pulse();
        feed(TOTAL, 1'b0, 100, 1'b0);
        repeat (3) tick();
        check_tbl(5, 5);
        chk("restart_strobes", 64'(log_n), 64'(TOTAL));
        chk("restart_done_cycles", 64'(done_cyc), 64'h1);

        // Asynchronous reset mid-load, then a fresh load
        clear_logs();
        start_pulse();
        feed(500, 1'b0, -1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cen", 64'(cen), 64'hFF);
        chk("arst_wen", 64'(wen), 64'hFF);
        chk("arst_busy", 64'(busy), 64'h0);
        chk("arst_ready", 64'(din_ready), 64'h0);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("arst_stays_idle", 64'(din_ready), 64'h0);
        clear_logs();
        start_pulse();
        feed(1, 1'b0, -1, 1'b0);
        tick();
        chk("arst_new_bank", 64'(log_bank[0]), 64'h0);
        chk("arst_new_addr", 64'(log_addr[0]), 64'h0);
        feed(TOTAL - 1, 1'b0, -1, 1'b0);
        repeat (3) tick();
        chk("arst_new_done", 64'(done_cyc), 64'h1);

`ifdef KERSRAM_W_CHKSUM_EN
        start_pulse();
        feed(TOTAL, 1'b0, -1, 1'b1);
        chk("chk_done", 64'(done), 64'h1);
        chk("chk_at_done", 64'(chks), 64'h2400);
        repeat (3) tick();
        chk("chk_stable", 64'(chks), 64'h2400);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
